// File: rtl/vitals_report_scheduler.sv
// Heart-rate averaging and periodic vitals report launcher.
// Averages beat-to-beat BPM over four beats and hands snapshots to a UART framer once per report period.
module vitals_report_scheduler #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned REPORT_CYCLES = 50_000_000,
  parameter int unsigned MIN_BPM       = 30,
  parameter int unsigned MAX_BPM       = 200,
  parameter int unsigned TX_TIMEOUT    = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_pulse,
  input  logic [7:0]  spo2_in,
  input  logic        spo2_valid,
  input  logic        tx_done,
  output logic [15:0] heart_rate,
  output logic [7:0]  spo2,
  output logic        start_tx,
  output logic        hr_valid,
  output logic        report_drop,
  output logic        tx_timeout,
  output logic [1:0]  dbg_state
);

  localparam logic [63:0] NUM64    = 64'(60) * 64'(CLK_HZ);
  localparam logic [31:0] DIVIDEND = NUM64[31:0];
  localparam logic [31:0] MIN_INT  = 32'(NUM64 / 64'(MAX_BPM));
  localparam logic [31:0] MAX_INT  = 32'(NUM64 / 64'(MIN_BPM));
  localparam logic [31:0] RC_LAST  = 32'(REPORT_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_WAIT = 2'd2} state_t;

  // Beat interval tracking: armed_q low means the next beat only restarts the counter.
  logic [31:0] ivl_q;
  logic        armed_q;
  logic        stale, beat_accept;

  assign stale       = ivl_q > MAX_INT;
  assign beat_accept = beat_pulse && armed_q && !stale && (ivl_q >= MIN_INT);

  always_ff @(posedge clk) begin
    if (rst) begin
      ivl_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (stale) armed_q <= 1'b0;
      if (beat_pulse && (!armed_q || stale)) begin
        ivl_q   <= '0;
        armed_q <= 1'b1;
      end else if (beat_accept) begin
        ivl_q <= '0;
      end else if (ivl_q != '1) begin
        ivl_q <= ivl_q + 32'd1;
      end
    end
  end

  // Serial restoring divider with a one-deep request queue.
  logic [31:0] dvs_q, quo_q, rem_q, qivl_q, rem_nx, quo_nx;
  logic [32:0] rem_sh, diff;
  logic [5:0]  step_q;
  logic        busy_q, qreq_q, div_ge, div_last;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    div_ge = !diff[32];
    rem_nx = div_ge ? diff[31:0] : rem_sh[31:0];
    quo_nx = {quo_q[30:0], div_ge};
  end

  assign div_last = busy_q && (step_q == 6'd31);

  always_ff @(posedge clk) begin
    if (rst || stale) begin
      busy_q <= 1'b0;
      qreq_q <= 1'b0;
      qivl_q <= '0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      if (busy_q) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        step_q <= step_q + 6'd1;
      end
      if (!busy_q || div_last) begin
        if (beat_accept || qreq_q) begin
          busy_q <= 1'b1;
          step_q <= '0;
          rem_q  <= '0;
          quo_q  <= DIVIDEND;
          dvs_q  <= beat_accept ? ivl_q : qivl_q;
          qreq_q <= 1'b0;
        end else begin
          busy_q <= 1'b0;
        end
      end else if (beat_accept) begin
        qreq_q <= 1'b1;
        qivl_q <= ivl_q;
      end
    end
  end

  // Four-entry BPM window; the final divider step pushes its quotient directly.
  logic [3:0][15:0] win_q;
  logic [2:0]       wcnt_q;
  logic [17:0]      win_sum;
  logic [15:0]      hr_live;

  always_ff @(posedge clk) begin
    if (rst || stale) begin
      win_q  <= '0;
      wcnt_q <= '0;
    end else if (div_last) begin
      win_q <= {win_q[2:0], quo_nx[15:0]};
      if (wcnt_q != 3'd4) wcnt_q <= wcnt_q + 3'd1;
    end
  end

  assign win_sum = 18'(win_q[0]) + 18'(win_q[1]) + 18'(win_q[2]) + 18'(win_q[3]);
  assign hr_live = (wcnt_q == 3'd4) ? 16'(win_sum >> 2) : 16'd0;

  // Report period timer; tick marks the last cycle of each period.
  logic [31:0] tmr_q;
  logic        tick;

  assign tick = (tmr_q == RC_LAST);

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tick ? 32'd0 : tmr_q + 32'd1;
  end

  // Framer handshake: start_tx is a single-cycle launch strobe; the framer answers by
  // raising tx_done, and only a 0->1 transition of tx_done observed in WAIT_DONE completes it.
  state_t      state_q;
  logic [31:0] to_q;
  logic [15:0] heart_rate_q;
  logic [7:0]  spo2_q;
  logic        pend_q, done_prev_q, start_tx_q, hr_valid_q, drop_q, tout_q, done_rise;

  assign done_rise = tx_done && !done_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      to_q         <= '0;
      heart_rate_q <= '0;
      spo2_q       <= '0;
      pend_q       <= 1'b0;
      done_prev_q  <= 1'b0;
      start_tx_q   <= 1'b0;
      hr_valid_q   <= 1'b0;
      drop_q       <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      start_tx_q  <= 1'b0;
      drop_q      <= 1'b0;
      tout_q      <= 1'b0;
      done_prev_q <= tx_done;
      if (state_q == S_IDLE) begin
        heart_rate_q <= hr_live;
        hr_valid_q   <= (wcnt_q == 3'd4);
      end
      if (state_q != S_IDLE && tick) begin
        if (pend_q) drop_q <= 1'b1;
        else        pend_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick || pend_q) begin
            state_q    <= S_LAUNCH;
            start_tx_q <= 1'b1;
            spo2_q     <= spo2_valid ? spo2_in : 8'd0;
            pend_q     <= 1'b0;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          to_q    <= '0;
        end
        S_WAIT: begin
          if (done_rise) begin
            state_q <= S_IDLE;
          end else if (to_q == TO_LAST) begin
            state_q <= S_IDLE;
            tout_q  <= 1'b1;
          end else begin
            to_q <= to_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign heart_rate  = heart_rate_q;
  assign spo2        = spo2_q;
  assign start_tx    = start_tx_q;
  assign hr_valid    = hr_valid_q;
  assign report_drop = drop_q;
  assign tx_timeout  = tout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vitals_report_scheduler.sv
// Bench for vitals_report_scheduler: one instance exercises heart-rate averaging,
// a second with a short report period exercises the report launcher.
module tb_vitals_report_scheduler;

  localparam int CLK_HZ  = 1000;
  localparam int MIN_BPM = 30;
  localparam int MAX_BPM = 200;
  localparam int MIN_INT = 60 * CLK_HZ / MAX_BPM;
  localparam int MAX_INT = 60 * CLK_HZ / MIN_BPM;
  localparam int RC      = 100;
  localparam int TO      = 400;

  // clock / reset
  logic clk = 1'b0;
  logic rst_hr = 1'b1, rst_tx = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // heart-rate instance
  logic        beat_hr = 1'b0;
  logic [7:0]  hr_spo2_in = 8'd0;
  logic        hr_spo2_valid = 1'b0, hr_tx_done = 1'b0;
  logic [15:0] hr_heart_rate;
  logic [7:0]  hr_spo2;
  logic        hr_start, hr_valid, hr_drop, hr_tout;
  logic [1:0]  hr_dbg;

  vitals_report_scheduler #(
    .CLK_HZ(CLK_HZ), .REPORT_CYCLES(1_000_000), .MIN_BPM(MIN_BPM),
    .MAX_BPM(MAX_BPM), .TX_TIMEOUT(TO)
  ) u_hr (
    .clk(clk), .rst(rst_hr), .beat_pulse(beat_hr), .spo2_in(hr_spo2_in),
    .spo2_valid(hr_spo2_valid), .tx_done(hr_tx_done), .heart_rate(hr_heart_rate),
    .spo2(hr_spo2), .start_tx(hr_start), .hr_valid(hr_valid), .report_drop(hr_drop),
    .tx_timeout(hr_tout), .dbg_state(hr_dbg)
  );

  // report instance
  logic        beat_tx = 1'b0;
  logic [7:0]  spo2_in = 8'd0;
  logic        spo2_valid = 1'b0, tx_done = 1'b0;
  logic [15:0] tx_heart_rate;
  logic [7:0]  tx_spo2;
  logic        tx_start, tx_valid, tx_drop, tx_tout;
  logic [1:0]  tx_dbg;

  vitals_report_scheduler #(
    .CLK_HZ(CLK_HZ), .REPORT_CYCLES(RC), .MIN_BPM(MIN_BPM),
    .MAX_BPM(MAX_BPM), .TX_TIMEOUT(TO)
  ) u_tx (
    .clk(clk), .rst(rst_tx), .beat_pulse(beat_tx), .spo2_in(spo2_in),
    .spo2_valid(spo2_valid), .tx_done(tx_done), .heart_rate(tx_heart_rate),
    .spo2(tx_spo2), .start_tx(tx_start), .hr_valid(tx_valid), .report_drop(tx_drop),
    .tx_timeout(tx_tout), .dbg_state(tx_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // heart-rate reference: windows of accepted BPM values
  int m_armed, m_last, last_beat;
  int m_win[$];

  function automatic int m_hr();
    int s = 0;
    if (m_win.size() != 4) return 0;
    foreach (m_win[i]) s += m_win[i];
    return s >> 2;
  endfunction

  task automatic m_beat(input int e);
    int ivl;
    ivl = e - m_last - 1;
    if (m_armed == 0 || ivl > MAX_INT) begin
      m_win.delete();
      m_armed = 1;
      m_last  = e;
    end else if (ivl >= MIN_INT) begin
      m_win.push_back((60 * CLK_HZ / ivl) & 16'hFFFF);
      if (m_win.size() > 4) void'(m_win.pop_front());
      m_last = e;
    end
  endtask

  // report event monitor
  logic [31:0] launch_q[$], drop_q[$], tout_q[$], exp_q[$], exp_drop_q[$];
  logic [7:0]  lspo_q[$];
  int          t0;

  always @(negedge clk) begin
    if (tx_start) begin
      launch_q.push_back(32'(cyc));
      lspo_q.push_back(tx_spo2);
    end
    if (tx_drop) drop_q.push_back(32'(cyc));
    if (tx_tout) tout_q.push_back(32'(cyc));
  end

  // driver tasks
  task automatic run_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hr_reset();
    @(posedge clk);
    #1 rst_hr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_hr = 1'b0;
    m_armed = 0;
    m_last = cyc;
    last_beat = cyc;
    m_win.delete();
  endtask

  task automatic hr_beat(input int gap);
    @(posedge clk);
    #1;
    run_to(last_beat + gap - 1);
    beat_hr = 1'b1;
    @(posedge clk);
    #1 beat_hr = 1'b0;
    last_beat = cyc;
    m_beat(cyc);
  endtask

  task automatic settle();
    repeat (50) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tx_reset();
    @(posedge clk);
    #1 rst_tx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_tx = 1'b0;
    t0 = cyc;
    launch_q.delete(); lspo_q.delete(); drop_q.delete(); tout_q.delete();
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({hr_heart_rate, hr_spo2, hr_start, hr_valid, hr_drop, hr_tout, hr_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_hr outputs got %h want 0", {hr_heart_rate, hr_spo2, hr_start, hr_valid, hr_drop, hr_tout, hr_dbg});
    end
    n_tests++;
    if ({tx_heart_rate, tx_spo2, tx_start, tx_valid, tx_drop, tx_tout, tx_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_tx outputs got %h want 0", {tx_heart_rate, tx_spo2, tx_start, tx_valid, tx_drop, tx_tout, tx_dbg});
    end
  endtask

  task automatic test_hr_seq(input string name, input int n, input int gaps[8]);
    hr_reset();
    for (int i = 0; i < n; i++) begin
      hr_beat(gaps[i]);
      settle();
      n_tests++;
      if (hr_heart_rate !== 16'(m_hr())) begin
        n_fail++;
        $display("FAIL %s[%0d] heart_rate got %0d want %0d", name, i, hr_heart_rate, m_hr());
      end
      n_tests++;
      if (hr_valid !== (m_win.size() == 4)) begin
        n_fail++;
        $display("FAIL %s[%0d] hr_valid got %0b want %0b", name, i, hr_valid, m_win.size() == 4);
      end
    end
  endtask

  task automatic test_hr_average();
    test_hr_seq("hr_average", 5, '{1000, 1000, 1000, 1000, 1000, 0, 0, 0});
    n_tests++;
    if (hr_heart_rate !== 16'd60 || hr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hr_average_final got %0d/%0b want 60/1", hr_heart_rate, hr_valid);
    end
  endtask

  task automatic test_hr_flush();
    repeat (2500) @(posedge clk);
    #1;
    if (m_armed != 0 && (cyc - m_last) > MAX_INT + 3) begin
      m_win.delete();
      m_armed = 0;
    end
    @(negedge clk);
    n_tests++;
    if (hr_heart_rate !== 16'(m_hr()) || hr_valid !== (m_win.size() == 4)) begin
      n_fail++;
      $display("FAIL hr_flush got %0d/%0b want %0d/%0b", hr_heart_rate, hr_valid, m_hr(), m_win.size() == 4);
    end
    hr_beat(10);
    hr_beat(1000);
    settle();
    n_tests++;
    if (hr_heart_rate !== 16'(m_hr()) || hr_valid !== (m_win.size() == 4)) begin
      n_fail++;
      $display("FAIL hr_after_flush got %0d/%0b want %0d/%0b", hr_heart_rate, hr_valid, m_hr(), m_win.size() == 4);
    end
  endtask

  task automatic test_hr_random();
    int gap, kind;
    hr_reset();
    for (int i = 0; i < 25; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2)      gap = $urandom_range(60, MIN_INT);
      else if (kind < 9) gap = $urandom_range(MIN_INT + 1, MAX_INT + 1);
      else               gap = $urandom_range(MAX_INT + 100, MAX_INT + 400);
      hr_beat(gap);
      settle();
      n_tests++;
      if (hr_heart_rate !== 16'(m_hr()) || hr_valid !== (m_win.size() == 4)) begin
        n_fail++;
        $display("FAIL hr_random[%0d] gap %0d got %0d/%0b want %0d/%0b", i, gap, hr_heart_rate, hr_valid, m_hr(), m_win.size() == 4);
      end
    end
  endtask

  task automatic test_tx_timeout();
    logic [7:0] v8;
    int first, tout, pend;
    v8 = 8'($urandom_range(1, 254));
    spo2_in = v8; spo2_valid = 1'b1; tx_done = 1'b1;
    tx_reset();
    first = t0 + RC;
    tout  = first + 1 + TO;
    exp_q = '{32'(first), 32'(tout + 1)};
    exp_drop_q.delete();
    pend = 0;
    for (int c = t0 + RC - 1; c < tout; c += RC)
      if (c >= first) begin
        if (pend != 0) exp_drop_q.push_back(32'(c + 1));
        else pend = 1;
      end
    run_to(t0 + 200);
    spo2_in = ~v8;
    run_to(t0 + 300);
    @(negedge clk);
    n_tests++;
    if (tx_spo2 !== v8) begin
      n_fail++;
      $display("FAIL tx_timeout_spo2_hold got %0d want %0d", tx_spo2, v8);
    end
    run_to(t0 + 510);
    @(negedge clk);
    n_tests++;
    if (launch_q != exp_q) begin
      n_fail++;
      $display("FAIL tx_timeout_launches got %p want %p", launch_q, exp_q);
    end
    n_tests++;
    if (lspo_q.size() != 2 || lspo_q[0] !== v8 || lspo_q[1] !== ~v8) begin
      n_fail++;
      $display("FAIL tx_timeout_snapshots got %p want %0d,%0d", lspo_q, v8, ~v8);
    end
    n_tests++;
    if (tout_q.size() != 1 || tout_q[0] !== 32'(tout)) begin
      n_fail++;
      $display("FAIL tx_timeout_pulse got %p want %0d", tout_q, tout);
    end
    n_tests++;
    if (drop_q != exp_drop_q) begin
      n_fail++;
      $display("FAIL tx_timeout_drops got %p want %p", drop_q, exp_drop_q);
    end
  endtask

  task automatic test_tx_done(input string name, input int lag);
    int first, done_c, pend;
    spo2_in = 8'($urandom_range(1, 255)); spo2_valid = 1'b0; tx_done = 1'b0;
    tx_reset();
    first  = t0 + RC;
    done_c = first + lag;
    exp_q  = '{32'(first), 32'(done_c + 2)};
    exp_drop_q.delete();
    pend = 0;
    for (int c = t0 + RC - 1; c <= done_c; c += RC)
      if (c >= first) begin
        if (pend != 0) exp_drop_q.push_back(32'(c + 1));
        else pend = 1;
      end
    run_to(done_c);
    tx_done = 1'b1;
    run_to(done_c + 20);
    @(negedge clk);
    n_tests++;
    if (launch_q != exp_q) begin
      n_fail++;
      $display("FAIL %s_launches got %p want %p", name, launch_q, exp_q);
    end
    n_tests++;
    if (drop_q != exp_drop_q) begin
      n_fail++;
      $display("FAIL %s_drops got %p want %p", name, drop_q, exp_drop_q);
    end
    n_tests++;
    if (tout_q.size() != 0 || lspo_q.size() != 2 || lspo_q[0] !== 8'd0 || lspo_q[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL %s_misc timeouts %p snapshots %p want none and 0,0", name, tout_q, lspo_q);
    end
    tx_done = 1'b0;
  endtask

  task automatic test_tx_reset();
    logic [7:0] v8;
    int t1;
    v8 = 8'($urandom_range(1, 255));
    spo2_in = v8; spo2_valid = 1'b1; tx_done = 1'b0;
    tx_reset();
    run_to(t0 + 150);
    @(negedge clk);
    n_tests++;
    if (tx_spo2 !== v8 || tx_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL tx_reset_pre spo2/state got %0d/%0d want %0d/2", tx_spo2, tx_dbg, v8);
    end
    @(posedge clk);
    #1 rst_tx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({tx_heart_rate, tx_spo2, tx_start, tx_valid, tx_drop, tx_tout, tx_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL tx_reset_outputs got %h want 0", {tx_heart_rate, tx_spo2, tx_start, tx_valid, tx_drop, tx_tout, tx_dbg});
    end
    @(posedge clk);
    #1 rst_tx = 1'b0;
    t1 = cyc;
    launch_q.delete(); lspo_q.delete(); drop_q.delete(); tout_q.delete();
    exp_q = '{32'(t1 + RC)};
    run_to(t1 + 150);
    @(negedge clk);
    n_tests++;
    if (launch_q != exp_q) begin
      n_fail++;
      $display("FAIL tx_reset_relaunch got %p want %p", launch_q, exp_q);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hr_average();
    test_hr_seq("hr_ignore", 6, '{500, 1500, 1200, 750, 100, 900, 0, 0});
    test_hr_seq("hr_bounds", 6, '{500, 301, 2001, 300, 700, 301, 0, 0});
    test_hr_flush();
    test_hr_random();
    test_tx_timeout();
    test_tx_done("tx_late_done", 250);
    test_tx_done("tick_and_done", RC - 1);
    test_tx_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
